// File: rtl/fp32_pkg.sv
// Shared FP32 types, constants, flag positions and sequencer state encoding.
package fp32_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam int          FP32_BIAS    = 127;
   localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
   localparam int          FP32_EXP_MAX = 255;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLASSIFY,
      S_WAIT,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   // Zero/denormal (treated as zero) or Inf/NaN: never needs the multiplier.
   function automatic logic fp32_is_special(input fp32_t x);
      return (x.exp == 8'h00) || (x.exp == 8'hFF);
   endfunction

endpackage

// File: rtl/fp32_mul_seq_if.sv
// Host operand/result handshake plus the mantissa-multiplier side channel.
interface fp32_mul_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;
   logic        mul_start;
   logic [23:0] mul_a;
   logic [23:0] mul_b;
   logic [47:0] mul_product;
   logic        mul_done;

   modport master (
      output in_valid, a, b, out_ready, mul_product, mul_done,
      input  in_ready, out_valid, result, flags, mul_start, mul_a, mul_b
   );

   modport slave (
      input  in_valid, a, b, out_ready, mul_product, mul_done,
      output in_ready, out_valid, result, flags, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/fp32_norm_round.sv
// Combinational normalize, round-to-nearest-even and pack of a 48-bit significand product.
module fp32_norm_round
   import fp32_pkg::*;
(
   input  logic              sign,
   input  logic signed [9:0] e,
   input  logic [47:0]       p,
   output logic [31:0]       result,
   output logic [3:0]        flags
);
   localparam logic signed [9:0] EXP_MAX10 = 10'(FP32_EXP_MAX);

   logic [22:0]       mant;
   logic [22:0]       mant_r;
   logic              g;
   logic              s;
   logic              rnd_up;
   logic              carry;
   logic signed [9:0] e_n;
   logic signed [9:0] e_r;

   always_comb begin
      if (p[47]) begin
         mant = p[46:24];
         g    = p[23];
         s    = |p[22:0];
         e_n  = e + 10'sd1;
      end else begin
         mant = p[45:23];
         g    = p[22];
         s    = |p[21:0];
         e_n  = e;
      end
      rnd_up          = g & (s | mant[0]);
      {carry, mant_r} = {1'b0, mant} + {23'd0, rnd_up};
      // A carry out of the fraction wraps mant_r to zero and bumps the exponent.
      e_r    = carry ? e_n + 10'sd1 : e_n;
      result = {sign, e_r[7:0], mant_r};
      flags  = '0;
      if (e_r >= EXP_MAX10) begin
         result                = {sign, 8'hFF, 23'd0};
         flags[FLAG_OVERFLOW]  = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end else if (e_r <= 10'sd0) begin
         result                = {sign, 31'd0};
         flags[FLAG_UNDERFLOW] = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end else begin
         flags[FLAG_INEXACT]   = g | s;
      end
   end
endmodule

// File: rtl/fp32_mul_seq.sv
// FP32 multiply sequencer around a shared 24x24 mantissa multiplier (FTZ/DAZ, RNE).
// Specials finish out of CLASSIFY; normal operands take multiplier latency + 3 cycles.
module fp32_mul_seq
   import fp32_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   fp32_mul_seq_if.slave bus
);
   localparam logic signed [9:0] BIAS10 = 10'(FP32_BIAS);

   state_t            state;
   fp32_t             in_a;
   fp32_t             in_b;
   fp32_t             a_q;
   fp32_t             b_q;
   logic              sign_q;
   logic signed [9:0] e_q;
   logic [47:0]       p_q;
   logic              out_valid_q;
   logic              mul_start_q;
   logic [31:0]       result_q;
   logic [3:0]        flags_q;
   logic [23:0]       mul_a_q;
   logic [23:0]       mul_b_q;
   logic [31:0]       nr_result;
   logic [3:0]        nr_flags;
   logic [31:0]       spec_result;
   logic [3:0]        spec_flags;
   logic              sign_ab;
   logic              a_nan, b_nan, a_snan, b_snan;
   logic              a_inf, b_inf, a_zero, b_zero;

   assign in_a    = bus.a;
   assign in_b    = bus.b;
   assign sign_ab = a_q.sign ^ b_q.sign;
   assign a_nan   = (a_q.exp == 8'hFF) && (a_q.frac != 23'd0);
   assign b_nan   = (b_q.exp == 8'hFF) && (b_q.frac != 23'd0);
   assign a_snan  = a_nan && !a_q.frac[22];
   assign b_snan  = b_nan && !b_q.frac[22];
   assign a_inf   = (a_q.exp == 8'hFF) && (a_q.frac == 23'd0);
   assign b_inf   = (b_q.exp == 8'hFF) && (b_q.frac == 23'd0);
   assign a_zero  = (a_q.exp == 8'h00);
   assign b_zero  = (b_q.exp == 8'h00);

   // Zero x finite is the fall-through case: signed zero, no flags.
   always_comb begin
      spec_result = {sign_ab, 31'd0};
      spec_flags  = '0;
      if (a_nan || b_nan) begin
         spec_result              = FP32_QNAN;
         spec_flags[FLAG_INVALID] = a_snan || b_snan;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         spec_result              = FP32_QNAN;
         spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_result              = {sign_ab, 8'hFF, 23'd0};
      end
   end

   fp32_norm_round u_norm_round (
      .sign   (sign_q),
      .e      (e_q),
      .p      (p_q),
      .result (nr_result),
      .flags  (nr_flags)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         out_valid_q <= 1'b0;
         mul_start_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         mul_start_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_q         <= in_a;
                  b_q         <= in_b;
                  mul_a_q     <= {1'b1, in_a.frac};
                  mul_b_q     <= {1'b1, in_b.frac};
                  // Screened early so the start pulse lands exactly in CLASSIFY.
                  mul_start_q <= !(fp32_is_special(in_a) || fp32_is_special(in_b));
                  state       <= S_CLASSIFY;
               end
            end
            S_CLASSIFY: begin
               sign_q <= sign_ab;
               e_q    <= $signed({2'b00, a_q.exp}) + $signed({2'b00, b_q.exp}) - BIAS10;
               if (fp32_is_special(a_q) || fp32_is_special(b_q)) begin
                  result_q    <= spec_result;
                  flags_q     <= spec_flags;
                  out_valid_q <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.mul_done) begin
                  p_q   <= bus.mul_product;
                  state <= S_NORM;
               end
            end
            S_NORM: begin
               result_q <= nr_result;
               flags_q  <= nr_flags;
               state    <= S_ROUND;
            end
            S_ROUND: begin
               out_valid_q <= 1'b1;
               state       <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_fp32_mul_seq.sv
// Bench for fp32_mul_seq: directed corner cases, reset abandonment and randomized operands
// against an arithmetic FP32 multiply reference, with a variable-latency multiplier model.
module tb_fp32_mul_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp   = 0;
   int   n_fail  = 0;
   int   mul_lat = 3;
   int   n_start = 0;

   fp32_mul_seq_if bus ();

   fp32_mul_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial forever #5 clk = ~clk;

   // Multiplier model: answers mul_lat cycles after the cycle its start pulse is seen.
   initial begin
      int          cnt;
      logic [47:0] prod;
      cnt = 0;
      prod = '0;
      bus.mul_done = 1'b0;
      bus.mul_product = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mul_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.mul_done = 1'b1;
               bus.mul_product = prod;
            end
         end
         if (bus.mul_start === 1'b1) begin
            n_start++;
            cnt = mul_lat;
            prod = {24'd0, bus.mul_a} * {24'd0, bus.mul_b};
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer product, rounded to 24 significant bits by remainder vs half.
   function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [3:0] f);
      logic sg, an, bn, asn, bsn, ai, bi, az, bz;
      int ea, eb, e, sh;
      longint unsigned prod, q, rem, half;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      sg  = a[31] ^ b[31];
      an  = (ea == 255) && (a[22:0] != 0);
      bn  = (eb == 255) && (b[22:0] != 0);
      asn = an && !a[22];
      bsn = bn && !b[22];
      ai  = (ea == 255) && (a[22:0] == 0);
      bi  = (eb == 255) && (b[22:0] == 0);
      az  = (ea == 0);
      bz  = (eb == 0);
      r = 32'h0;
      f = 4'h0;
      if (an || bn) begin
         r = 32'h7FC00000;
         f[3] = asn || bsn;
      end else if ((ai && bz) || (bi && az)) begin
         r = 32'h7FC00000;
         f[3] = 1'b1;
      end else if (ai || bi) begin
         r = {sg, 8'hFF, 23'h0};
      end else if (az || bz) begin
         r = {sg, 31'h0};
      end else begin
         prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
         sh   = ((prod >> 47) != 0) ? 24 : 23;
         e    = ea + eb - 127 + sh - 23;
         q    = prod >> sh;
         rem  = prod - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
         end
         if (e >= 255) begin
            r = {sg, 8'hFF, 23'h0};
            f = 4'b0101;
         end else if (e <= 0) begin
            r = {sg, 31'h0};
            f = 4'b0011;
         end else begin
            r = {sg, e[7:0], q[22:0]};
            f[0] = (rem != 0);
         end
      end
   endfunction

   function automatic logic [31:0] rand_op();
      if ($urandom_range(0, 3) == 0) begin
         case ($urandom_range(0, 7))
            0: return 32'h7F800000;
            1: return 32'hFF800000;
            2: return 32'h7FC00000;
            3: return 32'h7F800001;
            4: return 32'hFFA00000;
            5: return 32'h00000000;
            6: return 32'h80000000;
            default: return 32'h00000123;
         endcase
      end
      return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
   endfunction

   // One transaction from acceptance through handshake; called #1 after a rising edge.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold,
                         input logic [31:0] er, input logic [3:0] ef);
      int   cyc, start_cyc, starts0;
      logic special, moved, bad;
      special = (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
                (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
      mul_lat   = lat;
      starts0   = n_start;
      start_cyc = -1;
      moved     = 1'b0;
      bad       = 1'b0;
      check({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
      bus.a = a;
      bus.b = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      cyc = 1;
      while (bus.out_valid !== 1'b1 && cyc < 100) begin
         if (bus.mul_start === 1'b1 && start_cyc < 0) start_cyc = cyc;
         if (start_cyc >= 0 && cyc <= start_cyc + lat &&
             (bus.mul_a !== {1'b1, a[22:0]} || bus.mul_b !== {1'b1, b[22:0]})) moved = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (bus.out_valid !== 1'b1) begin
         check({tag, " timeout"}, 64'(bus.out_valid), 64'(1));
         return;
      end
      check({tag, " start_cycle"}, 64'(start_cyc), special ? 64'(-1) : 64'(1));
      check({tag, " start_pulses"}, 64'(n_start - starts0), special ? 64'(0) : 64'(1));
      check({tag, " out_cycle"}, 64'(cyc), special ? 64'(2) : 64'(4 + lat));
      if (!special) check({tag, " mul_ab"}, 64'(moved), 64'(0));
      check({tag, " result"}, 64'(bus.result), 64'(er));
      check({tag, " flags"}, 64'(bus.flags), 64'(ef));
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.result !== er || bus.flags !== ef) bad = 1'b1;
         end
         check({tag, " hold"}, 64'(bad), 64'(0));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, " out_valid_drop"}, 64'(bus.out_valid), 64'(0));
   endtask

   initial begin
      logic [31:0] ra, rb, er;
      logic [3:0]  ef;
      logic        bad;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst in_ready", 64'(bus.in_ready), 64'(1));
      check("rst out_valid", 64'(bus.out_valid), 64'(0));
      check("rst mul_start", 64'(bus.mul_start), 64'(0));
      check("rst result", 64'(bus.result), 64'(0));
      check("rst flags", 64'(bus.flags), 64'(0));
      check("rst mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'(0));

      run_op("unit", 32'h3F800000, 32'h3F800000, 3, 0, 32'h3F800000, 4'b0000);
      run_op("norm_shift", 32'h3FC00000, 32'h3FC00000, 2, 0, 32'h40100000, 4'b0000);
      run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 3, 0, 32'h7FC00000, 4'b1000);
      run_op("overflow", 32'h7F7FFFFF, 32'h40000000, 4, 0, 32'h7F800000, 4'b0101);
      run_op("underflow", 32'h00800000, 32'h3F000000, 1, 0, 32'h00000000, 4'b0011);
      run_op("rne_tie", 32'h3F800001, 32'h3FC00000, 2, 0, 32'h3FC00002, 4'b0001);
      run_op("backpressure", 32'h3FC00000, 32'hBFC00000, 3, 5, 32'hC0100000, 4'b0000);

      // Abandon a multiplication in WAIT; its late done must not revive the block.
      mul_lat = 8;
      bus.a = 32'h3F800000;
      bus.b = 32'h40400000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("abandon in_ready", 64'(bus.in_ready), 64'(1));
      check("abandon mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'(0));
      bad = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
      end
      check("stale_done", 64'(bad), 64'(0));

      for (int i = 0; i < 60; i++) begin
         ra = rand_op();
         rb = rand_op();
         ref_mul(ra, rb, er, ef);
         run_op($sformatf("rand%0d", i), ra, rb, int'($urandom_range(1, 6)),
                int'($urandom_range(0, 2)), er, ef);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
